sayeh_mem_responder: RTL and testbench
======================================

Name: sayeh_mem_responder

Overview:
- Memory-side responder for the Sayeh processor bus.
- Consumes the 16-bit address produced by the address logic, together with the datapath's readMem/writeMem strobes and write data.
- Services each request from an internal word-addressed RAM after a programmable number of wait states, then signals completion with memDataReady.
- Sits between the Sayeh datapath/controller and program/data storage; the controller stalls on memDataReady.

Parameters:
- ADDR_W, 16, width of addr_bus.
- DATA_W, 16, width of data_in and data_out.
- DEPTH_LOG2, 10, internal RAM holds 2**DEPTH_LOG2 words.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
- PROTECT_TOP, 16'h0040, first writable address; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- addr_bus  input  ADDR_W  word address from the address logic.
- data_in  input  DATA_W  write data.
- readMem  input  1  read request level.
- writeMem  input  1  write request level.
- data_out  output  DATA_W  read data, valid while memDataReady=1 after a read.
- memDataReady  output  1  one-cycle completion pulse.
- bus_err  output  1  one-cycle error pulse, coincident with memDataReady.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: data_out=0, memDataReady=0, bus_err=0, state=IDLE, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE: a request is readMem^writeMem=1, sampled on a clk edge.
  - On a request, latch addr_bus, data_in and the operation; load the counter with WAIT_STATES.
  - Go to WAIT, or straight to RESP when WAIT_STATES=0.
  - readMem=writeMem=1 in IDLE is an error request: go to RESP with the error flagged. No RAM access occurs.
- WAIT: decrement the counter; enter RESP when the counter reaches 1. Inputs are ignored; the latched values are used.
- RESP: lasts exactly one cycle, with memDataReady=1.
  - Read: data_out=RAM[addr].
  - Write: RAM[addr]<=data_in on the edge entering RESP; data_out is unchanged.
  - Then go to HOLD.
- HOLD: wait until readMem=writeMem=0, then go to IDLE. This prevents one held strobe from being serviced twice.
- Latency: a request sampled at edge N gives memDataReady high in the cycle after edge N+1+WAIT_STATES.
- Range check: an address >= 2**DEPTH_LOG2 raises bus_err with memDataReady.
  - No write occurs.
  - A read drives data_out=0.
- data_out holds its last read value between reads; it is cleared only by reset or an erroring read.
- Reset asserted mid-access: the access is aborted; a pending write is not committed unless its commit edge precedes reset assertion. The FSM restarts in IDLE.
- Strobes dropping in WAIT: the access still completes (it was accepted), then the FSM passes through HOLD.
- addr_bus upper bits above DEPTH_LOG2 are used only by the range check.

Optional Feature:
- Macro: SAYEH_MEM_WRITE_PROTECT_EN.
- Defined: writes to addresses < PROTECT_TOP are rejected. The response arrives with the normal latency, bus_err=1, and the RAM is unchanged. Reads are unaffected.
- Undefined: all in-range addresses are writable and the PROTECT_TOP parameter is ignored.

Decomposition:
- Shared package sayeh_mem_pkg holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, HOLD=2'd3);
  - the operation codes OP_READ and OP_WRITE;
  - the default widths ADDR_W and DATA_W.
- One natural sub-module, sayeh_mem_array: a single-port synchronous RAM (clk, we, addr, wdata, rdata) that keeps storage separate from the handshake FSM.

Test Plan:
- WAIT_STATES=1; write 16'hBEEF to 16'h0100, drop writeMem after the pulse, then read 16'h0100 -> memDataReady pulses exactly 2 cycles after each accepted request; read data_out=16'hBEEF; bus_err=0.
- WAIT_STATES=0; hold readMem high for 5 cycles at 16'h0005 -> exactly one memDataReady pulse, 1 cycle after acceptance; a second pulse appears only after readMem drops and rises again.
- readMem=writeMem=1 at 16'h0010 -> memDataReady=1 and bus_err=1 together; RAM[16'h0010] is unchanged on a subsequent read.
- DEPTH_LOG2=10; read 16'h0400 -> bus_err=1, data_out=0. Write 16'h1234 to 16'h0400, then read 16'h0000 -> the value is unchanged (no aliasing).
- WAIT_STATES=3; assert rst_n=0 during WAIT of a write of 16'hAAAA to 16'h0020 -> all outputs go to 0 immediately; RAM[16'h0020] retains its old value; the next request completes normally.
- With SAYEH_MEM_WRITE_PROTECT_EN: write 16'h5555 to 16'h003F -> bus_err=1 and the readback is the old value. Write to 16'h0040 -> bus_err=0 and the readback is 16'h5555.

Source files
------------

// File: rtl/sayeh_mem_pkg.sv
// rtl/sayeh_mem_pkg.sv - shared FSM encoding, operation codes and default widths for sayeh_mem_responder
package sayeh_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/sayeh_mem_array.sv
// rtl/sayeh_mem_array.sv - single-port synchronous word RAM backing the Sayeh memory responder
module sayeh_mem_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Registered read every cycle (old data on a same-cycle write); write when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/sayeh_mem_responder.sv
// rtl/sayeh_mem_responder.sv - wait-state memory responder for the Sayeh bus (option: SAYEH_MEM_WRITE_PROTECT_EN)
module sayeh_mem_responder #(
    parameter int                ADDR_W      = sayeh_mem_pkg::ADDR_W,
    parameter int                DATA_W      = sayeh_mem_pkg::DATA_W,
    parameter int                DEPTH_LOG2  = 10,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = 16'h0040
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] data_in,
    input  logic              readMem,
    input  logic              writeMem,
    output logic [DATA_W-1:0] data_out,
    output logic              memDataReady,
    output logic              bus_err
);

    import sayeh_mem_pkg::*;

`ifdef SAYEH_MEM_WRITE_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic [DATA_W-1:0]       r_wdata;
    op_t                     r_op;
    logic                    r_err;

    logic                    w_in_both;
    logic                    w_in_req;
    logic                    w_in_oob;
    logic                    w_in_prot;
    logic                    w_in_err;
    op_t                     w_in_op;
    logic                    w_idle;
    logic [DEPTH_LOG2-1:0]   w_cur_addr;
    logic [DATA_W-1:0]       w_cur_wdata;
    op_t                     w_cur_op;
    logic                    w_cur_err;
    logic                    w_enter_resp;
    logic                    w_we;
    logic [DATA_W-1:0]       w_rdata;

    // Request decode straight from the bus; only meaningful while IDLE
    assign w_in_both = readMem & writeMem;
    assign w_in_req  = readMem ^ writeMem;
    assign w_in_oob  = |addr_bus[ADDR_W-1:DEPTH_LOG2];
    assign w_in_prot = PROTECT_EN & writeMem & ~readMem & (addr_bus < PROTECT_TOP);
    assign w_in_err  = w_in_both | w_in_oob | w_in_prot;
    assign w_in_op   = writeMem ? OP_WRITE : OP_READ;

    // With zero wait states the RAM access happens on the accepting edge, so
    // the array sees the live bus in IDLE and the latched request otherwise.
    assign w_idle      = (r_state == IDLE);
    assign w_cur_addr  = w_idle ? addr_bus[DEPTH_LOG2-1:0] : r_addr;
    assign w_cur_wdata = w_idle ? data_in : r_wdata;
    assign w_cur_op    = w_idle ? w_in_op : r_op;
    assign w_cur_err   = w_idle ? w_in_err : r_err;

    assign w_enter_resp = (w_idle & (w_in_both | (w_in_req & (WAIT_STATES == 0))))
                        | ((r_state == WAIT) & (r_cnt == 4'd1));
    assign w_we         = w_enter_resp & (w_cur_op == OP_WRITE) & ~w_cur_err;

    sayeh_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_cur_addr),
        .wdata (w_cur_wdata),
        .rdata (w_rdata)
    );

    // Handshake FSM: accept, count wait states, respond once, then wait for strobes to drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op         <= OP_READ;
            r_err        <= 1'b0;
            data_out     <= '0;
            memDataReady <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            memDataReady <= 1'b0;
            bus_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_in_both || w_in_req) begin
                        r_addr  <= addr_bus[DEPTH_LOG2-1:0];
                        r_wdata <= data_in;
                        r_op    <= w_in_op;
                        r_err   <= w_in_err;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= w_enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    memDataReady <= 1'b1;
                    bus_err      <= r_err;
                    if (r_op == OP_READ) begin
                        data_out <= r_err ? '0 : w_rdata;
                    end
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (!readMem && !writeMem) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sayeh_mem_responder.sv
// tb/tb_sayeh_mem_responder.sv - self-checking bench for sayeh_mem_responder with 0, 1 and 3 wait states
module tb_sayeh_mem_responder;

`ifdef SAYEH_MEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    localparam logic [15:0] RST_A = PROT ? 16'h0120 : 16'h0020;

    logic        clk = 1'b0;
    logic        rstn [3];
    logic [15:0] addr [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic        rd   [3];
    logic        wr   [3];
    logic        rdy  [3];
    logic        err  [3];

    always #5 clk = ~clk;

    sayeh_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rstn[0]), .addr_bus(addr[0]), .data_in(din[0]),
        .readMem(rd[0]), .writeMem(wr[0]), .data_out(dout[0]),
        .memDataReady(rdy[0]), .bus_err(err[0]));

    sayeh_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rstn[1]), .addr_bus(addr[1]), .data_in(din[1]),
        .readMem(rd[1]), .writeMem(wr[1]), .data_out(dout[1]),
        .memDataReady(rdy[1]), .bus_err(err[1]));

    sayeh_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rstn[2]), .addr_bus(addr[2]), .data_in(din[2]),
        .readMem(rd[2]), .writeMem(wr[2]), .data_out(dout[2]),
        .memDataReady(rdy[2]), .bus_err(err[2]));

    int n_chk = 0;
    int n_err = 0;

    // reference memory per instance, plus the last value data_out should show
    logic [15:0] mem_m  [3][1024];
    bit          vld_m  [3][1024];
    logic [15:0] last_m [3];
    bit          lk_m   [3];

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [15:0] a;
        logic [15:0] dat;
        bit          early;
        int          lat;
        bit          e;
        bit          cq;
        logic [15:0] q;
    } vec_t;
    vec_t tbl [$];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic logic [15:0] pool_addr(input int i);
        case (i)
            0: return 16'h0000;
            1: return 16'h0041;
            2: return 16'h0100;
            3: return 16'h0155;
            4: return 16'h02AA;
            5: return 16'h03FE;
            6: return 16'h03FF;
            default: return 16'h0030;
        endcase
    endfunction

    function automatic logic [15:0] oob_addr(input int i);
        case (i)
            0: return 16'h0400;
            1: return 16'hFFFF;
            default: return 16'h8123;
        endcase
    endfunction

    function automatic void add(input int d, input bit r, input bit w, input logic [15:0] a,
                                input logic [15:0] dat, input bit early, input int lat,
                                input bit e, input bit cq, input logic [15:0] q);
        vec_t v;
        v.d = d; v.r = r; v.w = w; v.a = a; v.dat = dat; v.early = early;
        v.lat = lat; v.e = e; v.cq = cq; v.q = q;
        tbl.push_back(v);
    endfunction

    // Behavioural rules: what a request should report and how storage changes
    function automatic void model_apply(input int d, input bit r, input bit w, input logic [15:0] a,
                                        input logic [15:0] dat, output bit e,
                                        output logic [15:0] q, output bit qk);
        bit oob;
        int idx;
        oob = (a >= 16'd1024);
        idx = int'(a) % 1024;
        e = (r && w) || oob || (PROT && w && !r && a < 16'h0040);
        if (r && !w) begin
            if (oob) begin
                last_m[d] = 16'h0000;
                lk_m[d]   = 1'b1;
            end else begin
                last_m[d] = mem_m[d][idx];
                lk_m[d]   = vld_m[d][idx];
            end
        end else if (w && !r && !e) begin
            mem_m[d][idx] = dat;
            vld_m[d][idx] = 1'b1;
        end
        q  = last_m[d];
        qk = lk_m[d];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus transaction; lat counts clock edges from acceptance to the visible pulse
    task automatic xact(input int d, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] dat, input bit early,
                        output int lat, output logic [15:0] q, output bit e);
        lat = -1;
        q   = 16'h0000;
        e   = 1'b0;
        @(negedge clk);
        addr[d] = a; din[d] = dat; rd[d] = r; wr[d] = w;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                lat = i - 1;
                q   = dout[d];
                e   = err[d];
                break;
            end
            if (early) begin
                rd[d] = 1'b0; wr[d] = 1'b0;
                addr[d] = 16'($urandom); din[d] = 16'($urandom);
            end
        end
        chk($sformatf("pulse_seen_d%0d", d), {31'd0, lat >= 0}, 32'd1);
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("single_pulse_d%0d", d), {31'd0, rdy[d]}, 32'd0);
    endtask

    task automatic run_model_check(input int d, input bit r, input bit w, input logic [15:0] a,
                                   input logic [15:0] dat, input bit early);
        int          lat;
        logic [15:0] q;
        bit          e;
        bit          me;
        logic [15:0] mq;
        bit          mk;
        xact(d, r, w, a, dat, early, lat, q, e);
        model_apply(d, r, w, a, dat, me, mq, mk);
        if (!(r && w)) chk($sformatf("rnd_lat_d%0d_a%0h", d, a), lat, 1 + ws_of(d));
        chk($sformatf("rnd_err_d%0d_a%0h", d, a), {31'd0, e}, {31'd0, me});
        if (mk) chk($sformatf("rnd_dout_d%0d_a%0h", d, a), {16'd0, q}, {16'd0, mq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] q;
        bit          e;
        bit          me;
        logic [15:0] mq;
        bit          mk;
        int          pulses;
        int          first;
        int          k;
        bit          r;
        bit          w;
        logic [15:0] a;

        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
            last_m[d] = 16'h0000; lk_m[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_dout_d%0d", d), {16'd0, dout[d]}, 32'd0);
            chk($sformatf("reset_rdy_d%0d", d), {31'd0, rdy[d]}, 32'd0);
            chk($sformatf("reset_err_d%0d", d), {31'd0, err[d]}, 32'd0);
        end
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;

        // directed vectors: d, r, w, addr, data, early-drop, latency (0 = any), err, check dout, dout
        add(0, 0, 1, 16'h0100, 16'hBEEF, 0, 2, 0,     1,     16'h0000);
        add(0, 1, 0, 16'h0100, 16'h0000, 0, 2, 0,     1,     16'hBEEF);
        add(0, 0, 1, 16'h0010, 16'h1111, 1, 2, PROT,  1,     16'hBEEF);
        add(0, 1, 1, 16'h0010, 16'h2222, 0, 0, 1,     1,     16'hBEEF);
        add(0, 1, 0, 16'h0010, 16'h0000, 0, 2, 0,     !PROT, 16'h1111);
        add(0, 1, 0, 16'h0400, 16'h0000, 0, 2, 1,     1,     16'h0000);
        add(0, 0, 1, 16'h0000, 16'h0ABC, 0, 2, PROT,  1,     16'h0000);
        add(0, 0, 1, 16'h0400, 16'h1234, 0, 2, 1,     1,     16'h0000);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 2, 0,     !PROT, 16'h0ABC);
        add(0, 0, 1, 16'h03FF, 16'h7777, 0, 2, 0,     !PROT, 16'h0ABC);
        add(0, 1, 0, 16'h03FF, 16'h0000, 1, 2, 0,     1,     16'h7777);
        add(0, 1, 0, 16'hFFFF, 16'h0000, 0, 2, 1,     1,     16'h0000);
        add(1, 0, 1, 16'h0005, 16'h5A5A, 0, 1, PROT,  1,     16'h0000);
        add(1, 1, 0, 16'h0005, 16'h0000, 0, 1, 0,     !PROT, 16'h5A5A);
        add(1, 0, 1, 16'h0200, 16'hC3C3, 1, 1, 0,     !PROT, 16'h5A5A);
        add(1, 1, 0, 16'h0200, 16'h0000, 0, 1, 0,     1,     16'hC3C3);
        add(2, 0, 1, RST_A,    16'h1357, 0, 4, 0,     1,     16'h0000);
        add(2, 1, 0, RST_A,    16'h0000, 0, 4, 0,     1,     16'h1357);

        for (int i = 0; i < tbl.size(); i++) begin
            xact(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].early, lat, q, e);
            model_apply(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, me, mq, mk);
            if (tbl[i].lat > 0) chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].e});
            if (tbl[i].cq) chk($sformatf("tbl%0d_dout", i), {16'd0, q}, {16'd0, tbl[i].q});
        end

        // held readMem with zero wait states: one pulse per strobe assertion
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            addr[1] = 16'h0005; rd[1] = 1'b1;
            pulses = 0; first = -1; q = 16'h0000;
            for (int i = 1; i <= 5; i++) begin
                @(negedge clk);
                if (rdy[1]) begin
                    pulses++;
                    if (first < 0) first = i;
                    q = dout[1];
                end
            end
            rd[1] = 1'b0;
            model_apply(1, 1'b1, 1'b0, 16'h0005, 16'h0000, me, mq, mk);
            chk($sformatf("hold%0d_pulses", pass), pulses, 1);
            chk($sformatf("hold%0d_when", pass), first, 2);
            if (mk) chk($sformatf("hold%0d_dout", pass), {16'd0, q}, {16'd0, mq});
            @(negedge clk);
        end

        // reset asserted while a write is still counting wait states
        @(negedge clk);
        addr[2] = RST_A; din[2] = 16'hAAAA; wr[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        chk("rst_mid_dout", {16'd0, dout[2]}, 32'd0);
        chk("rst_mid_rdy", {31'd0, rdy[2]}, 32'd0);
        chk("rst_mid_err", {31'd0, err[2]}, 32'd0);
        wr[2] = 1'b0;
        last_m[2] = 16'h0000; lk_m[2] = 1'b1;
        @(negedge clk);
        rstn[2] = 1'b1;
        xact(2, 1'b1, 1'b0, RST_A, 16'h0000, 1'b0, lat, q, e);
        model_apply(2, 1'b1, 1'b0, RST_A, 16'h0000, me, mq, mk);
        chk("rst_after_lat", lat, 4);
        chk("rst_after_err", {31'd0, e}, 32'd0);
        chk("rst_after_dout", {16'd0, q}, 32'h1357);

`ifdef SAYEH_MEM_WRITE_PROTECT_EN
        xact(0, 1'b0, 1'b1, 16'h003F, 16'h5555, 1'b0, lat, q, e);
        model_apply(0, 1'b0, 1'b1, 16'h003F, 16'h5555, me, mq, mk);
        chk("prot_3f_lat", lat, 2);
        chk("prot_3f_err", {31'd0, e}, 32'd1);
        xact(0, 1'b1, 1'b0, 16'h003F, 16'h0000, 1'b0, lat, q, e);
        model_apply(0, 1'b1, 1'b0, 16'h003F, 16'h0000, me, mq, mk);
        chk("prot_3f_kept", {31'd0, q != 16'h5555}, 32'd1);
        xact(0, 1'b0, 1'b1, 16'h0040, 16'h5555, 1'b0, lat, q, e);
        model_apply(0, 1'b0, 1'b1, 16'h0040, 16'h5555, me, mq, mk);
        chk("prot_40_err", {31'd0, e}, 32'd0);
        xact(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, lat, q, e);
        model_apply(0, 1'b1, 1'b0, 16'h0040, 16'h0000, me, mq, mk);
        chk("prot_40_dout", {16'd0, q}, 32'h5555);
`endif

        // randomized traffic against the reference model
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                k = $urandom_range(0, 99);
                if (k < 45) begin
                    r = 1'b1; w = 1'b0;
                end else if (k < 85) begin
                    r = 1'b0; w = 1'b1;
                end else if (k < 90) begin
                    r = 1'b1; w = 1'b1;
                end else begin
                    r = 1'($urandom_range(0, 1)); w = ~r;
                end
                if (k >= 90) a = oob_addr($urandom_range(0, 2));
                else         a = pool_addr($urandom_range(0, 7));
                run_model_check(d, r, w, a, 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
